stage_fetch: RTL and testbench

STAGE_FETCH -- requirements
Module: stage_fetch

---
 rtl/stage_fetch.sv | 109 ++++++++++
 tb/tb_stage_fetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/stage_fetch.sv
// Instruction fetch stage: reads one opcode per request from program memory,
// offers it downstream with a drdy/ack_in handshake, and stops at an all-zero opcode.
package stage_fetch_pkg;
  localparam int OPCODE_MSB = 7;
endpackage

module stage_fetch
  import stage_fetch_pkg::*;
#(
  parameter  int ADDR_W = 12,
  localparam int W      = OPCODE_MSB + 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [W-1:0]      imem_data,
  output logic [W-1:0]      operation,
  output logic              drdy,
  input  logic              ack_in,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [1:0] {FETCH, WAIT, ISSUE, HALT} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [W-1:0]      operation_next;
  logic              drdy_next;
  logic              halted_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= '0;
      operation <= '0;
      drdy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      operation <= operation_next;
      drdy      <= drdy_next;
      halted    <= halted_next;
    end
  end

  // A jump always wins: it redirects pc and restarts at FETCH, so any read
  // already in flight is simply never captured.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    operation_next = operation;
    drdy_next      = drdy;
    halted_next    = halted;
    unique case (state)
      FETCH: begin
        if (jump) begin
          pc_next    = jump_target;
          drdy_next  = 1'b0;
          state_next = FETCH;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (jump) begin
          pc_next    = jump_target;
          drdy_next  = 1'b0;
          state_next = FETCH;
        end else if (imem_data != '0) begin
          operation_next = imem_data;
          drdy_next      = 1'b1;
          state_next     = ISSUE;
        end else begin
          drdy_next   = 1'b0;
          halted_next = 1'b1;
          state_next  = HALT;
        end
      end
      ISSUE: begin
        if (jump) begin
          pc_next    = jump_target;
          drdy_next  = 1'b0;
          state_next = FETCH;
        end else if (ack_in) begin
          pc_next    = pc + ADDR_W'(1);
          drdy_next  = 1'b0;
          state_next = FETCH;
        end
      end
      HALT: begin
        drdy_next  = 1'b0;
        state_next = HALT;
      end
      default: state_next = FETCH;
    endcase
  end

  // Gated by reset so no read is issued while the stage is held in reset.
  always_comb begin
    imem_rd   = (state == FETCH) && !reset;
    imem_addr = pc;
  end

endmodule

// File: tb/tb_stage_fetch.sv
// Directed bench for stage_fetch with a registered-read program memory model.
module tb_stage_fetch;

  localparam int ADDR_W = 12;
  localparam int W      = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd;
  logic [W-1:0]      imem_data = '0;
  logic [W-1:0]      operation;
  logic              drdy;
  logic              ack_in;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  logic [W-1:0] mem [0:(1<<ADDR_W)-1];

  int total_count = 0;
  int pass_count  = 0;

  stage_fetch #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_data  (imem_data),
    .operation  (operation),
    .drdy       (drdy),
    .ack_in     (ack_in),
    .jump       (jump),
    .jump_target(jump_target),
    .pc         (pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Program memory: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem[imem_addr];
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_count++;
    assert (observed === expected) pass_count++;
    else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h11;
    mem[0] = 8'h03;
    mem[1] = 8'h05;
    mem[2] = 8'h00;
    reset = 1'b1;
    ack_in = 1'b1;
    jump = 1'b0;
    jump_target = '0;

    // Reset state while reset is held
    step();
    check("rst_pc", pc, 0);
    check("rst_drdy", drdy, 0);
    check("rst_halted", halted, 0);
    check("rst_op", operation, 0);
    check("rst_rd", imem_rd, 0);

    // Program 3,5,0 with ack tied high
    reset = 1'b0;
    #1;
    check("t1_fetch_rd", imem_rd, 1);
    check("t1_fetch_addr", imem_addr, 0);
    step();
    check("t1_wait_rd", imem_rd, 0);
    check("t1_wait_drdy", drdy, 0);
    step();
    check("t1_op0", operation, 8'h03);
    check("t1_drdy0", drdy, 1);
    step();
    check("t1_drop0", drdy, 0);
    check("t1_pc1", pc, 1);
    step();
    step();
    check("t1_op1", operation, 8'h05);
    check("t1_drdy1", drdy, 1);
    step();
    check("t1_drop1", drdy, 0);
    check("t1_pc2", pc, 2);
    step();
    check("t1_halt_pre", halted, 0);
    step();
    check("t1_halted", halted, 1);
    check("t1_halt_drdy", drdy, 0);
    check("t1_halt_pc", pc, 2);

    // Jump while halted is ignored
    jump = 1'b1;
    jump_target = 12'd5;
    #1;
    check("t1_halt_rd_jump", imem_rd, 0);
    step();
    jump = 1'b0;
    check("t1_halt_jump_pc", pc, 2);
    check("t1_halt_jump_halted", halted, 1);
    check("t1_halt_jump_rd", imem_rd, 0);
    step();
    check("t1_halt_stay_drdy", drdy, 0);

    // Backpressure: hold ack low for 10 cycles
    mem[0] = 8'h07;
    ack_in = 1'b0;
    pulse_reset();
    check("t2_halt_cleared", halted, 0);
    step();
    step();
    check("t2_op", operation, 8'h07);
    check("t2_drdy", drdy, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("t2_hold_drdy", drdy, 1);
      check("t2_hold_op", operation, 8'h07);
      check("t2_hold_pc", pc, 0);
    end
    ack_in = 1'b1;
    step();
    ack_in = 1'b0;
    check("t2_ack_pc", pc, 1);
    check("t2_ack_drdy", drdy, 0);

    // Jump beats ack in ISSUE; jump in WAIT discards the pending read
    mem[4]  = 8'h09;
    mem[20] = 8'h21;
    mem[21] = 8'h22;
    mem[30] = 8'h44;
    pulse_reset();
    jump = 1'b1;
    jump_target = 12'd4;
    step();
    jump = 1'b0;
    check("t3_jump_pc4", pc, 4);
    step();
    step();
    check("t3_op4", operation, 8'h09);
    check("t3_drdy4", drdy, 1);
    jump = 1'b1;
    jump_target = 12'd20;
    ack_in = 1'b1;
    step();
    jump = 1'b0;
    check("t3_prio_pc", pc, 20);
    check("t3_prio_drdy", drdy, 0);
    step();
    step();
    check("t3_op20", operation, 8'h21);
    check("t3_drdy20", drdy, 1);
    step();
    check("t3_pc21", pc, 21);
    step();
    jump = 1'b1;
    jump_target = 12'd30;
    step();
    jump = 1'b0;
    check("t3_wait_jump_pc", pc, 30);
    check("t3_wait_jump_drdy", drdy, 0);
    check("t3_wait_jump_rd", imem_rd, 1);
    step();
    step();
    check("t3_op30", operation, 8'h44);

    // pc wraps from all-ones to zero
    mem[4095] = 8'h55;
    pulse_reset();
    jump = 1'b1;
    jump_target = 12'hFFF;
    step();
    jump = 1'b0;
    check("t4_pc_max", pc, 12'hFFF);
    step();
    step();
    check("t4_op_max", operation, 8'h55);
    step();
    check("t4_wrap_pc", pc, 0);
    check("t4_wrap_addr", imem_addr, 0);
    check("t4_wrap_rd", imem_rd, 1);
    step();
    step();
    check("t4_op0", operation, 8'h07);

    // Asynchronous reset mid-ISSUE
    step();
    ack_in = 1'b0;
    check("t5_pc1", pc, 1);
    step();
    step();
    check("t5_op1", operation, 8'h05);
    check("t5_drdy1", drdy, 1);
    #3;
    reset = 1'b1;
    #1;
    check("t5_async_drdy", drdy, 0);
    check("t5_async_op", operation, 0);
    check("t5_async_pc", pc, 0);
    check("t5_async_rd", imem_rd, 0);
    step();
    reset = 1'b0;
    #1;
    check("t5_resume_rd", imem_rd, 1);
    step();
    step();
    check("t5_resume_op", operation, 8'h07);
    check("t5_resume_drdy", drdy, 1);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
